// File: rtl/block_store_if.sv
// Lookup, kill and refill signals shared by the game logic, the renderer and
// the brick store. The store is the slave side; the master side drives addresses and commands.
interface block_store_if;
  logic [6:0] render_addr;
  logic       render_alive;
  logic [6:0] query_addr;
  logic       query_alive;
  logic       kill;
  logic [6:0] kill_addr;
  logic       kill_hit;
  logic       refill;
  logic       busy;
  logic [6:0] blocks_left;
  logic       all_cleared;

  modport master (
    output render_addr, query_addr, kill, kill_addr, refill,
    input  render_alive, query_alive, kill_hit, busy, blocks_left, all_cleared
  );

  modport slave (
    input  render_addr, query_addr, kill, kill_addr, refill,
    output render_alive, query_alive, kill_hit, busy, blocks_left, all_cleared
  );
endinterface

// File: rtl/block_store.sv
// Alive/destroyed state of every brick, with two same-cycle lookup ports, a kill
// command, a refill sequencer that writes one brick per clock, and a live-brick count.
module block_store #(
  parameter int NUM_BLOCKS = 100
) (
  input  logic         clk,
  input  logic         rst,
  block_store_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  localparam logic [7:0] NB   = 8'(NUM_BLOCKS);
  localparam logic [6:0] LAST = 7'(NUM_BLOCKS - 1);

  state_t     state, state_nx;
  logic [6:0] fill_cnt, fill_cnt_nx;
  logic [6:0] left, left_nx;
  logic       hit, hit_nx;
  logic       cleared, cleared_nx;
  logic       wr_en, wr_data;
  logic [6:0] wr_addr;
  logic       kill_live;

  logic alive_mem [NUM_BLOCKS];

  // Reads are gated to zero while filling so half-written contents never leak out.
  assign bus.render_alive = (state == ST_IDLE) && ({1'b0, bus.render_addr} < NB)
                            && alive_mem[bus.render_addr];
  assign bus.query_alive  = (state == ST_IDLE) && ({1'b0, bus.query_addr} < NB)
                            && alive_mem[bus.query_addr];
  assign kill_live        = ({1'b0, bus.kill_addr} < NB) && alive_mem[bus.kill_addr];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx    = state;
    fill_cnt_nx = fill_cnt;
    left_nx     = left;
    hit_nx      = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = fill_cnt;
    wr_data     = 1'b0;
    case (state)
      ST_FILL: begin
        if (bus.refill) begin
          fill_cnt_nx = '0;
          left_nx     = '0;
        end else begin
          wr_en       = 1'b1;
          wr_data     = 1'b1;
          fill_cnt_nx = fill_cnt + 7'd1;
          left_nx     = left + 7'd1;
          if (fill_cnt == LAST) state_nx = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // Refill takes priority; a kill in the same cycle is dropped.
        if (bus.refill) begin
          state_nx    = ST_FILL;
          fill_cnt_nx = '0;
          left_nx     = '0;
        end else if (bus.kill && kill_live) begin
          wr_en   = 1'b1;
          wr_addr = bus.kill_addr;
          left_nx = left - 7'd1;
          hit_nx  = 1'b1;
        end
      end
    endcase
    cleared_nx = (state_nx == ST_IDLE) && (left_nx == 7'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FILL;
      fill_cnt <= '0;
      left     <= '0;
      hit      <= 1'b0;
      cleared  <= 1'b0;
    end else begin
      state    <= state_nx;
      fill_cnt <= fill_cnt_nx;
      left     <= left_nx;
      hit      <= hit_nx;
      cleared  <= cleared_nx;
    end
  end

  // NOTE: the array has no reset; the fill sequence that follows every reset initialises it.
  always_ff @(posedge clk) begin
    if (wr_en) alive_mem[wr_addr] <= wr_data;
  end

  assign bus.busy        = (state == ST_FILL);
  assign bus.blocks_left = left;
  assign bus.kill_hit    = hit;
  assign bus.all_cleared = cleared;

endmodule

// File: tb/tb_block_store.sv
// Directed bench for block_store: reset fill, kills, clear-all, refill priority,
// restarted fills with ignored kills, and an asynchronous mid-operation reset.
`timescale 1ns/1ps
module tb_block_store;

  localparam int NUM = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hits;

  block_store_if bus ();

  block_store #(.NUM_BLOCKS(NUM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expects the caller to have launched a fill on the edge just before; checks k edges after it.
  task automatic run_fill(input int n);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("fill_left", 32'(bus.blocks_left), k);
      check("fill_busy", bus.busy, (k < NUM) ? 1 : 0);
      check("fill_hit", bus.kill_hit, 0);
      check("fill_cleared", bus.all_cleared, 0);
      if (k < NUM) check("fill_query_zero", bus.query_alive, 0);
    end
  endtask

  task automatic do_kill(input logic [6:0] a, input logic exp_before, input logic exp_hit,
                         input logic [6:0] exp_left);
    @(posedge clk);
    #1;
    bus.kill = 1'b1;
    bus.kill_addr = a;
    bus.query_addr = a;
    bus.render_addr = a;
    #1;
    check("kill_pre_query", bus.query_alive, exp_before);
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    @(negedge clk);
    check("kill_hit", bus.kill_hit, exp_hit);
    check("kill_left", 32'(bus.blocks_left), 32'(exp_left));
    check("kill_post_query", bus.query_alive, 0);
    check("kill_post_render", bus.render_alive, 0);
  endtask

  task automatic kill_range(input int first, input int count);
    hits = 0;
    for (int i = first; i < first + count; i++) begin
      @(posedge clk);
      #1;
      bus.kill = 1'b1;
      bus.kill_addr = 7'(i);
      @(negedge clk);
      hits += int'(bus.kill_hit);
    end
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    @(negedge clk);
    hits += int'(bus.kill_hit);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.render_addr = '0;
    bus.query_addr  = '0;
    bus.kill        = 1'b0;
    bus.kill_addr   = '0;
    bus.refill      = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 1);
    check("rst_left", 32'(bus.blocks_left), 0);
    check("rst_hit", bus.kill_hit, 0);
    check("rst_cleared", bus.all_cleared, 0);
    check("rst_render", bus.render_alive, 0);
    check("rst_query", bus.query_alive, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_fill(NUM);

    // Render sweep over the full address range
    for (int a = 0; a < 128; a++) begin
      bus.render_addr = 7'(a);
      #1;
      check("sweep_render", bus.render_alive, (a < NUM) ? 1 : 0);
    end

    // Kill sequence
    do_kill(7'd5, 1'b1, 1'b1, 7'd99);
    do_kill(7'd5, 1'b0, 1'b0, 7'd99);
    do_kill(7'd120, 1'b0, 1'b0, 7'd99);
    check("kill_cleared", bus.all_cleared, 0);

    // REFILL and KILL together: refill wins
    @(posedge clk);
    #1;
    bus.refill = 1'b1;
    bus.kill = 1'b1;
    bus.kill_addr = 7'd3;
    @(posedge clk);
    #1;
    bus.refill = 1'b0;
    bus.kill = 1'b0;
    @(negedge clk);
    check("both_hit", bus.kill_hit, 0);
    check("both_busy", bus.busy, 1);
    check("both_left", 32'(bus.blocks_left), 0);
    run_fill(NUM);
    bus.query_addr = 7'd3;
    #1;
    check("both_alive3", bus.query_alive, 1);
    bus.query_addr = 7'd5;
    #1;
    check("refilled_alive5", bus.query_alive, 1);

    // Clear all
    kill_range(0, NUM);
    check("clear_hits", 32'(hits), 100);
    check("clear_left", 32'(bus.blocks_left), 0);
    check("clear_cleared", bus.all_cleared, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("clear_cleared_holds", bus.all_cleared, 1);

    // REFILL clears the flag; kills during the fill are ignored; a second REFILL restarts
    @(posedge clk);
    #1;
    bus.refill = 1'b1;
    @(posedge clk);
    #1;
    bus.refill = 1'b0;
    bus.kill = 1'b1;
    bus.kill_addr = 7'd0;
    @(negedge clk);
    check("refill_cleared", bus.all_cleared, 0);
    check("refill_busy", bus.busy, 1);
    run_fill(40);
    @(posedge clk);
    #1;
    bus.refill = 1'b1;
    @(posedge clk);
    #1;
    bus.refill = 1'b0;
    bus.kill = 1'b0;
    @(negedge clk);
    check("restart_left", 32'(bus.blocks_left), 0);
    check("restart_busy", bus.busy, 1);
    run_fill(NUM);
    bus.render_addr = 7'd0;
    #1;
    check("restart_alive0", bus.render_alive, 1);

    // Asynchronous reset in IDLE with 37 bricks left
    kill_range(0, 63);
    check("pre_rst_hits", 32'(hits), 63);
    check("pre_rst_left", 32'(bus.blocks_left), 37);
    bus.render_addr = 7'd70;
    #1;
    check("pre_rst_render", bus.render_alive, 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_busy", bus.busy, 1);
    check("async_left", 32'(bus.blocks_left), 0);
    check("async_render", bus.render_alive, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_fill(NUM);
    bus.render_addr = 7'd99;
    #1;
    check("final_alive99", bus.render_alive, 1);
    bus.render_addr = 7'd10;
    #1;
    check("final_alive10", bus.render_alive, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
